// File: rtl/rv32i_rtype_topk.sv
// Top-K selection accelerator on the R-type offload port: logit storage, sequential row scan, ranked readback.
// Optional build macro TOPK_NAN_SKIP_EN: NaN elements are not inserted and each one sets err.
module rv32i_rtype_topk #(
    parameter int M      = 8,
    parameter int N      = 8,
    parameter int DATA_W = 32,
    parameter int K      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [4:0]  rd_addr,
    output logic        rd_we,
    output logic [4:0]  rd_waddr,
    output logic [31:0] rd_wdata,
    output logic        accel_busy,
    output logic        accel_done,
    output logic        accel_C_valid
);
    localparam int ROW_W = (M > 1) ? $clog2(M) : 1;
    localparam int COL_W = (N > 1) ? $clog2(N) : 1;
    localparam int KR_W  = (K > 1) ? $clog2(K) : 1;

    localparam logic [2:0] F_XWR   = 3'b000;
    localparam logic [2:0] F_START = 3'b001;
    localparam logic [2:0] F_STAT  = 3'b010;
    localparam logic [2:0] F_RIDX  = 3'b011;
    localparam logic [2:0] F_RMAX  = 3'b100;
    localparam logic [2:0] F_CLR   = 3'b101;

    typedef enum logic {S_IDLE, S_SCAN} state_e;

    state_e                   state_q, state_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic                     done_q, done_d, cval_q, cval_d;
    logic                     err_q, err_d, ovf_q, ovf_d;
    logic [K-1:0]             occ_q, occ_d;
    logic [COL_W-1:0]         idx_q [K];
    logic [COL_W-1:0]         idx_d [K];
    logic [DATA_W-1:0]        val_q [K];
    logic [DATA_W-1:0]        val_d [K];
    logic [DATA_W-1:0]        mem [1 << (ROW_W + COL_W)];

    logic                     accept, busy, rank_ok, mem_we, ins_en, is_inf;
    logic [2:0]               f3;
    logic [KR_W-1:0]          rank_sel;
    logic [DATA_W-1:0]        elem, ekey;
    logic [K-1:0]             ge, ge_prev;
    logic                     unused_ok;

    // -0 and +0 share one key so ties between them fall back to index order
    function automatic logic [DATA_W-1:0] fkey(input logic [DATA_W-1:0] x);
        if (x[DATA_W-2:0] == '0) return {1'b1, {(DATA_W-1){1'b0}}};
        return x[DATA_W-1] ? ~x : {1'b1, x[DATA_W-2:0]};
    endfunction

    assign instr_ready   = 1'b1;
    assign f3            = instr[14:12];
    assign accept        = instr_valid && (instr[6:0] == 7'h33) && (instr[31:25] == 7'h06);
    assign busy          = (state_q == S_SCAN);
    assign rank_ok       = (rs1_val < 32'(K));
    assign rank_sel      = rs1_val[KR_W-1:0];
    assign mem_we        = accept && (f3 == F_XWR) && !busy && !rst;
    assign elem          = mem[{row_q, col_q}];
    assign ekey          = fkey(elem);
    assign is_inf        = (elem[DATA_W-2:DATA_W-9] == 8'hFF) && (elem[DATA_W-10:0] == '0);
    assign accel_busy    = busy;
    assign accel_done    = done_q;
    assign accel_C_valid = cval_q;
    assign unused_ok     = &{1'b0, instr[24:15], instr[11:7]};

`ifdef TOPK_NAN_SKIP_EN
    logic is_nan;
    assign is_nan = (elem[DATA_W-2:DATA_W-9] == 8'hFF) && (elem[DATA_W-10:0] != '0);
    assign ins_en = busy && !ge[K-1] && !is_nan;
`else
    assign ins_en = busy && !ge[K-1];
`endif

    always_comb begin
        ge      = '0;
        ge_prev = '0;
        for (int unsigned i = 0; i < K; i++) ge[i] = occ_q[i] && (fkey(val_q[i]) >= ekey);
        ge_prev[0] = 1'b1;
        for (int unsigned i = 1; i < K; i++) ge_prev[i] = ge[i-1];
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        done_d  = done_q;
        cval_d  = cval_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        occ_d   = occ_q;
        idx_d   = idx_q;
        val_d   = val_q;
        if (busy) begin
            if (is_inf) ovf_d = 1'b1;
`ifdef TOPK_NAN_SKIP_EN
            if (is_nan) err_d = 1'b1;
`endif
            // Slots ranking at or above the new key stay; the first losing slot takes the new element
            if (ins_en) begin
                for (int unsigned i = 0; i < K; i++) begin
                    if (!ge[i]) begin
                        if (ge_prev[i]) begin
                            occ_d[i] = 1'b1;
                            idx_d[i] = col_q;
                            val_d[i] = elem;
                        end else begin
                            occ_d[i] = occ_q[i-1];
                            idx_d[i] = idx_q[i-1];
                            val_d[i] = val_q[i-1];
                        end
                    end
                end
            end
            col_d = col_q + COL_W'(1);
            if (col_q == COL_W'(N - 1)) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                cval_d  = 1'b1;
            end
        end
        if (accept) begin
            case (f3)
                F_XWR: if (busy) err_d = 1'b1;
                F_START: begin
                    if (busy) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_SCAN;
                        row_d   = rs1_val[ROW_W-1:0];
                        col_d   = '0;
                        done_d  = 1'b0;
                        cval_d  = 1'b0;
                        ovf_d   = 1'b0;
                        occ_d   = '0;
`ifdef TOPK_NAN_SKIP_EN
                        idx_d   = '{default: '1};
`else
                        idx_d   = '{default: '0};
`endif
                        val_d   = '{default: '0};
                    end
                end
                F_RIDX, F_RMAX: if (!rank_ok) err_d = 1'b1;
                F_CLR: begin
                    if (busy) begin
                        err_d = 1'b1;
                    end else begin
                        done_d = 1'b0;
                        cval_d = 1'b0;
                        err_d  = 1'b0;
                        ovf_d  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_we    = 1'b0;
        rd_waddr = '0;
        rd_wdata = '0;
        if (accept) begin
            case (f3)
                F_STAT: begin
                    rd_we    = 1'b1;
                    rd_wdata = {27'b0, err_q, ovf_q, cval_q, done_q, busy};
                end
                F_RIDX: begin
                    rd_we = 1'b1;
                    if (rank_ok) rd_wdata = 32'(idx_q[rank_sel]);
                end
                F_RMAX: begin
                    rd_we = 1'b1;
                    if (rank_ok) rd_wdata = val_q[rank_sel];
                end
                default: ;
            endcase
            if (rd_we) rd_waddr = rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
            cval_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            occ_q   <= '0;
            idx_q   <= '{default: '0};
            val_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            done_q  <= done_d;
            cval_q  <= cval_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            occ_q   <= occ_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[rs1_val[ROW_W+COL_W-1:0]] <= rs2_val;
    end
endmodule

// File: tb/tb_rv32i_rtype_topk.sv
// Scoreboard bench for rv32i_rtype_topk: expectations queued at issue, compared at writeback.
module tb_rv32i_rtype_topk;
    localparam int K = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr, rs1_val, rs2_val, rd_wdata;
    logic [4:0]  rd_addr, rd_waddr;
    logic        rd_we, accel_busy, accel_done, accel_C_valid;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] rows [8][8];
    logic [31:0] exp_q [$];

    rv32i_rtype_topk #(.M(8), .N(8), .DATA_W(32), .K(4)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
        .rd_we(rd_we), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
        .accel_busy(accel_busy), .accel_done(accel_done), .accel_C_valid(accel_C_valid)
    );

    always #5 clk = ~clk;

    // Drive one instruction from a negedge; outputs sampled 1 time unit later, mid-cycle
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rd, output logic we, output logic [4:0] wa);
        instr       = {7'h06, 10'd0, f3, 5'd0, 7'h33};
        rs1_val     = a;
        rs2_val     = b;
        rd_addr     = 5'd9;
        instr_valid = 1'b1;
        #1;
        rd = rd_wdata;
        we = rd_we;
        wa = rd_waddr;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic load_row(input int r, input logic [31:0] v [8]);
        logic [31:0] d; logic w; logic [4:0] a;
        for (int c = 0; c < 8; c++) begin
            rows[r][c] = v[c];
            issue(3'b000, 32'(r * 8 + c), v[c], d, w, a);
        end
    endtask

    // Strictly greater in IEEE order; +0 and -0 are equal
    function automatic bit fgt(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 0 && b[30:0] == 0) return 0;
        if (a[31] != b[31]) return !a[31];
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    task automatic push_model(input int r);
        bit used [8];
        int best;
        for (int j = 0; j < 8; j++) used[j] = 0;
        for (int k = 0; k < K; k++) begin
            best = -1;
            for (int j = 0; j < 8; j++)
                if (!used[j] && (best < 0 || fgt(rows[r][j], rows[r][best]))) best = j;
            used[best] = 1;
            exp_q.push_back(32'(best));
            exp_q.push_back(rows[r][best]);
        end
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] d; logic w; logic [4:0] a;
        int n = 0;
        d = '0;
        while (n < 40 && d[1] !== 1'b1) begin
            issue(3'b010, 0, 0, d, w, a);
            n++;
        end
        if (d[1] !== 1'b1) begin
            checks++; failures++;
            $display("FAIL %s_timeout got=%h need done", tag, d);
        end
    endtask

    task automatic test_reset;
        logic [31:0] d, e; logic w; logic [4:0] a;
        exp_q.push_back(32'h0);
        issue(3'b010, 0, 0, d, w, a);
        e = exp_q.pop_front(); checks++;
        if (d !== e || w !== 1'b1 || a !== 5'd9) begin
            failures++; $display("FAIL reset_stat got=%h we=%b wa=%0d exp=%h", d, w, a, e);
        end
        exp_q.push_back(32'h0);
        issue(3'b011, 0, 0, d, w, a);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin failures++; $display("FAIL reset_ridx got=%h exp=%h", d, e); end
        instr = {7'h00, 10'd0, 3'b010, 5'd0, 7'h33};
        instr_valid = 1'b1;
        #1; checks++;
        if (rd_we !== 1'b0) begin failures++; $display("FAIL ignored_we got=%b exp=0", rd_we); end
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic test_basic;
        logic [31:0] d, e; logic w; logic [4:0] a;
        logic [31:0] v [8] = '{32'h3F800000, 32'h40200000, 32'hC0400000, 32'h41100000,
                               32'h40800000, 32'h41000000, 32'h00000000, 32'hBF800000};
        load_row(0, v);
        issue(3'b001, 0, 0, d, w, a);
        for (int i = 1; i <= 9; i++) begin
            exp_q.push_back(i <= 8 ? 32'h01 : 32'h06);
            issue(3'b010, 0, 0, d, w, a);
            e = exp_q.pop_front(); checks++;
            if (d !== e) begin failures++; $display("FAIL basic_stat%0d got=%h exp=%h", i, d, e); end
        end
        push_model(0);
        for (int r = 0; r < K; r++) begin
            issue(3'b011, r, 0, d, w, a);
            e = exp_q.pop_front(); checks++;
            if (d !== e || w !== 1'b1) begin failures++; $display("FAIL basic_ridx%0d got=%h exp=%h", r, d, e); end
            issue(3'b100, r, 0, d, w, a);
            e = exp_q.pop_front(); checks++;
            if (d !== e) begin failures++; $display("FAIL basic_rmax%0d got=%h exp=%h", r, d, e); end
        end
    endtask

    task automatic test_tie;
        logic [31:0] d, e; logic w; logic [4:0] a;
        logic [31:0] v [8] = '{32'h80000000, 32'hBF800000, 32'h40A00000, 32'hC0000000,
                               32'hC0400000, 32'h40A00000, 32'h00000000, 32'hC0800000};
        load_row(2, v);
        issue(3'b001, 2, 0, d, w, a);
        wait_done("tie");
        push_model(2);
        for (int r = 0; r < K; r++) begin
            issue(3'b011, r, 0, d, w, a);
            e = exp_q.pop_front(); checks++;
            if (d !== e) begin failures++; $display("FAIL tie_ridx%0d got=%h exp=%h", r, d, e); end
            issue(3'b100, r, 0, d, w, a);
            e = exp_q.pop_front(); checks++;
            if (d !== e) begin failures++; $display("FAIL tie_rmax%0d got=%h exp=%h", r, d, e); end
        end
    endtask

    task automatic test_multirow;
        logic [31:0] d, e; logic w; logic [4:0] a;
        logic [31:0] v [8] = '{32'h40E00000, 32'hC1200000, 32'h41A00000, 32'h3F000000,
                               32'h42C80000, 32'hC2C80000, 32'h40400000, 32'h41200000};
        load_row(7, v);
        issue(3'b001, 7, 0, d, w, a);
        wait_done("multirow");
        push_model(7);
        for (int r = 0; r < K; r++) begin
            issue(3'b011, r, 0, d, w, a);
            e = exp_q.pop_front(); checks++;
            if (d !== e) begin failures++; $display("FAIL multi_ridx%0d got=%h exp=%h", r, d, e); end
            issue(3'b100, r, 0, d, w, a);
            e = exp_q.pop_front(); checks++;
            if (d !== e) begin failures++; $display("FAIL multi_rmax%0d got=%h exp=%h", r, d, e); end
        end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h16);
        issue(3'b011, 4, 0, d, w, a);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin failures++; $display("FAIL rank_oob got=%h exp=%h", d, e); end
        issue(3'b010, 0, 0, d, w, a);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin failures++; $display("FAIL rank_oob_stat got=%h exp=%h", d, e); end
        issue(3'b101, 0, 0, d, w, a);
    endtask

    task automatic test_back_to_back;
        logic [31:0] d, e; logic w; logic [4:0] a;
        issue(3'b001, 0, 0, d, w, a);
        issue(3'b000, 32'd3, 32'h4F000000, d, w, a);
        issue(3'b001, 7, 0, d, w, a);
        exp_q.push_back(32'h11);
        issue(3'b010, 0, 0, d, w, a);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin failures++; $display("FAIL busy_stat got=%h exp=%h", d, e); end
        wait_done("busy");
        push_model(0);
        for (int r = 0; r < K; r++) begin
            issue(3'b011, r, 0, d, w, a);
            e = exp_q.pop_front(); checks++;
            if (d !== e) begin failures++; $display("FAIL busy_ridx%0d got=%h exp=%h", r, d, e); end
            issue(3'b100, r, 0, d, w, a);
            e = exp_q.pop_front(); checks++;
            if (d !== e) begin failures++; $display("FAIL busy_rmax%0d got=%h exp=%h", r, d, e); end
        end
        exp_q.push_back(32'h16);
        exp_q.push_back(32'h00);
        issue(3'b010, 0, 0, d, w, a);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin failures++; $display("FAIL busy_err_stat got=%h exp=%h", d, e); end
        issue(3'b101, 0, 0, d, w, a);
        issue(3'b010, 0, 0, d, w, a);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin failures++; $display("FAIL clr_stat got=%h exp=%h", d, e); end
    endtask

    task automatic test_special;
        logic [31:0] d, e; logic w; logic [4:0] a;
        logic [31:0] v [8] = '{32'h7FC00000, 32'h7F800000, 32'h3F800000, 32'h40000000,
                               32'h40400000, 32'hBF800000, 32'hC0000000, 32'hC0400000};
`ifdef TOPK_NAN_SKIP_EN
        logic [31:0] ei [4] = '{32'd1, 32'd4, 32'd3, 32'd2};
        logic [31:0] ev [4] = '{32'h7F800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        logic [31:0] es = 32'h1E;
`else
        logic [31:0] ei [4] = '{32'd0, 32'd1, 32'd4, 32'd3};
        logic [31:0] ev [4] = '{32'h7FC00000, 32'h7F800000, 32'h40400000, 32'h40000000};
        logic [31:0] es = 32'h0E;
`endif
        load_row(3, v);
        issue(3'b001, 3, 0, d, w, a);
        wait_done("special");
        for (int r = 0; r < K; r++) begin
            exp_q.push_back(ei[r]);
            exp_q.push_back(ev[r]);
        end
        for (int r = 0; r < K; r++) begin
            issue(3'b011, r, 0, d, w, a);
            e = exp_q.pop_front(); checks++;
            if (d !== e) begin failures++; $display("FAIL spec_ridx%0d got=%h exp=%h", r, d, e); end
            issue(3'b100, r, 0, d, w, a);
            e = exp_q.pop_front(); checks++;
            if (d !== e) begin failures++; $display("FAIL spec_rmax%0d got=%h exp=%h", r, d, e); end
        end
        exp_q.push_back(es);
        issue(3'b010, 0, 0, d, w, a);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin failures++; $display("FAIL spec_stat got=%h exp=%h", d, e); end
        issue(3'b101, 0, 0, d, w, a);
    endtask

    task automatic test_reset_midscan;
        logic [31:0] d, e; logic w; logic [4:0] a;
        issue(3'b001, 0, 0, d, w, a);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h01);
            issue(3'b010, 0, 0, d, w, a);
            e = exp_q.pop_front(); checks++;
            if (d !== e) begin failures++; $display("FAIL mid_stat%0d got=%h exp=%h", i, d, e); end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        issue(3'b010, 0, 0, d, w, a);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin failures++; $display("FAIL rst_stat got=%h exp=%h", d, e); end
        issue(3'b011, 0, 0, d, w, a);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin failures++; $display("FAIL rst_ridx got=%h exp=%h", d, e); end
        issue(3'b100, 0, 0, d, w, a);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin failures++; $display("FAIL rst_rmax got=%h exp=%h", d, e); end
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        rs1_val     = '0;
        rs2_val     = '0;
        rd_addr     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset;
        test_basic;
        test_tie;
        test_multirow;
        test_back_to_back;
        test_special;
        test_reset_midscan;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rv32i_rtype_topk.md
# rv32i_rtype_topk

Custom RV32I R-type accelerator that generalises the single-row argmax unit to top-K selection over any of M stored rows of N FP32 logits. It sits beside the core's execute stage on the same instruction-offload interface: logits are written one at a time, a START scans one row sequentially, and the K largest values and their column indices are read back by rank. It serves classifier heads that need top-1/top-5 results without a software sort.

## Interface
- M, 8: rows of logit storage.
- N, 8: logits per row. N ≥ 2.
- DATA_W, 32: element width. Only 32 (IEEE-754 binary32) is supported.
- K, 4: result slots. 1 ≤ K ≤ N.
- ROW_W, COL_W, KR_W: derived as max(1, clog2(M)), max(1, clog2(N)) and max(1, clog2(K)).

Ports:
- clk  in  1  Clock.
- rst  in  1  Reset: synchronous, active-high.
- instr_valid  in  1  Instruction offered.
- instr_ready  out  1  Tied to 1; every valid instruction is accepted in its cycle.
- instr  in  32  R-type word: opcode 7'h33, funct7 7'h06, decode on funct3.
- rs1_val  in  32  Operand 1.
- rs2_val  in  32  Operand 2.
- rd_addr  in  5  Destination register.
- rd_we  out  1  Writeback strobe.
- rd_waddr  out  5  Writeback register.
- rd_wdata  out  32  Writeback data.
- accel_busy  out  1  Scan in progress.
- accel_done  out  1  Sticky: last scan completed.
- accel_C_valid  out  1  Result list holds a completed scan.

## Operation
- An instruction is accepted when instr_valid=1 and instr[6:0]=7'h33 and instr[31:25]=7'h06. Any other word is ignored and produces no writeback.
- funct3 000 XWR: store rs2_val at row rs1_val[ROW_W+COL_W-1:COL_W], column rs1_val[COL_W-1:0]. No writeback.
- funct3 001 START: scan row rs1_val[ROW_W-1:0]. Sets busy, clears done and C_valid, and empties the result list. No writeback.
- funct3 010 STAT: rd = {27'b0, err, ovf, C_valid, done, busy}, packed as bits [4:0].
- funct3 011 RIDX: returns the column index of rank rs1_val[KR_W-1:0], zero-extended. Rank 0 is the largest value.
- funct3 100 RMAX: returns the value bits of that rank.
- funct3 101 CLR: clears done, C_valid and err. Storage is kept. No writeback.
- funct3 110 and 111: no action, no writeback.
- RIDX/RMAX corner cases:
  - Rank ≥ K returns 32'h0 and sets err.
  - Reading while C_valid=0 returns the current partial list; this is not an error.
- Busy-time conflicts: XWR, START or CLR accepted while busy are dropped and set the sticky err bit. STAT, RIDX and RMAX are always serviced.
- Scan: one element per cycle, columns 0..N-1 in order. Each element is inserted into a sorted list of K slots:
  - Insert position p = number of occupied slots whose key ≥ the new key.
  - If p < K, slots p..K-2 shift down one place and the element is written at slot p. Otherwise it is discarded.
  - Ties therefore keep the smaller index at the better rank.
- Ordering key: binary32 total order. A positive value maps to {1, bits[30:0]}; a negative value maps to ~bits. -0 and +0 compare equal; the earlier index wins.
- ovf (sticky until START or CLR): set when any scanned element is ±inf.

## Timing
- Reset values:
  - busy, done, C_valid, err, ovf: 0.
  - rd_we: 0; rd_waddr and rd_wdata: 0.
  - Result slots: empty, index 0, value 32'h0.
  - Logit storage is not reset.
- Writeback is combinational in the accept cycle: rd_we = accept AND funct3 ∈ {010, 011, 100}; rd_waddr = rd_addr. Data is valid while instr_valid is held.
- START accepted at edge T:
  - busy=1 after T.
  - Element j is compared in cycle T+1+j.
  - The final insertion happens at edge T+N.
  - At that same edge busy→0, done→1, C_valid→1.
  - START-to-done latency is N cycles.
- XWR to the scanned row during a scan is dropped (busy rule), so a scan always sees a stable row.
- An XWR written at edge T is visible to a START accepted at edge T+1.
- rst asserted mid-scan: all state returns to reset values at the next edge and the partial list is discarded.

## Configuration
- TOPK_NAN_SKIP_EN defined:
  - Elements with exponent 8'hFF and a nonzero mantissa are not inserted.
  - Each NaN sets err.
  - If fewer than K valid elements exist, the unfilled slots read back value 32'h0 and index {COL_W{1'b1}}.
- Not defined: NaNs are ranked by the key above. Positive NaN ranks above +inf; negative NaN ranks below -inf.

## Test plan
- Row 0 = {1.0, 2.5, -3.0, 9.0, 4.0, 8.0, 0.0, -1.0}, K=4, START 0 → ranks 0..3 return idx {3, 5, 4, 1} and values {4110_0000, 4100_0000, 4080_0000, 4020_0000}. done is seen by STAT exactly N=8 cycles after START.
- Tie: row 2 has 5.0 at idx 2 and idx 5, plus -0.0 at idx 0 and +0.0 at idx 6 → rank 0 idx 2, rank 1 idx 5. Among the zeros, idx 0 ranks ahead of idx 6.
- Multi-row: rows 0 and 7 loaded with distinct data, START 7 → the results reflect row 7 only. RIDX with rank 4 (K=4) returns 0 and sets STAT bit 4.
- Busy conflicts: during a scan, XWR and START are issued → both dropped and err=1. STAT polls still return busy=1. The results match the unmodified row. A following CLR clears err.
- Special values: 7F80_0000 (+inf) at idx 1 → rank 0 idx 1 and ovf=1. With TOPK_NAN_SKIP_EN, 7FC0_0000 at idx 0 is skipped and err=1. Without the macro, the NaN takes rank 0.
- Reset: rst asserted 3 cycles into a scan → STAT reads 0. A RIDX read returns idx 0.
